// File: rtl/pitch_seq_pkg.sv
// Shared definitions for the pitch-shift frame sequencer: FSM states and the
// legal semitone range.
package pitch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } seq_state_t;

  localparam logic signed [4:0] SEMI_MIN = -5'sd12;
  localparam logic signed [4:0] SEMI_MAX = 5'sd12;

  function automatic logic semi_in_range(input logic signed [4:0] value);
    return (value >= SEMI_MIN) && (value <= SEMI_MAX);
  endfunction

endpackage

// File: rtl/pitch_shift_sequencer_if.sv
// Source-read, shift-datapath and destination-write buses of the sequencer.
// master = sequencer side, slave = memories/datapath side.
interface pitch_shift_sequencer_if #(
  parameter int SIZE = 32,
  parameter int IW   = 11
);
  logic            src_rd_en;
  logic [IW-1:0]   src_rd_addr;
  logic [SIZE-1:0] src_rd_data;

  logic [IW-1:0]   shf_in_index;
  logic [SIZE-1:0] shf_data_in;
  logic [IW-1:0]   shf_out_index;
  logic [SIZE-1:0] shf_data_out;
  logic            shf_ovf;

  logic            dst_wr_en;
  logic [IW-1:0]   dst_wr_addr;
  logic [SIZE-1:0] dst_wr_data;
  logic            dst_wr_ready;

  modport master (
    output src_rd_en, src_rd_addr,
    input  src_rd_data,
    output shf_in_index, shf_data_in,
    input  shf_out_index, shf_data_out, shf_ovf,
    output dst_wr_en, dst_wr_addr, dst_wr_data,
    input  dst_wr_ready
  );

  modport slave (
    input  src_rd_en, src_rd_addr,
    output src_rd_data,
    input  shf_in_index, shf_data_in,
    output shf_out_index, shf_data_out, shf_ovf,
    input  dst_wr_en, dst_wr_addr, dst_wr_data,
    output dst_wr_ready
  );
endinterface

// File: rtl/pitch_seq_cfg.sv
// Semitone configuration: pending register written at any time, active copy
// loaded only when a frame starts, sticky error on out-of-range writes.
module pitch_seq_cfg
  import pitch_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic signed [4:0] shift_semitones,
  input  logic              shift_wr_en,
  input  logic              load,
  output logic signed [4:0] semitones,
  output logic              cfg_err
);

  logic signed [4:0] pending_r;
  logic signed [4:0] active_r;
  logic              err_r;

  // pending/active semitone registers and sticky config error
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= 5'sd0;
      active_r  <= 5'sd0;
      err_r     <= 1'b0;
    end else begin
      if (shift_wr_en) begin
        if (semi_in_range(shift_semitones)) begin
          pending_r <= shift_semitones;
        end else begin
          err_r <= 1'b1;
        end
      end
      // a write in the same cycle as load applies to the following frame
      if (load) begin
        active_r <= pending_r;
      end
    end
  end

  assign semitones = active_r;
  assign cfg_err   = err_r;

endmodule

// File: rtl/pitch_shift_sequencer.sv
// Frame sequencer: streams SAMPLES source bins through the pitch-shift datapath
// into destination memory. Optional pre-frame clear under PITCH_SEQ_CLEAR_EN.
module pitch_shift_sequencer
  import pitch_seq_pkg::*;
#(
  parameter int  SIZE    = 32,
  parameter int  SAMPLES = 2048,
  localparam int IW      = $clog2(SAMPLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic signed [4:0] shift_semitones,
  input  logic              shift_wr_en,
  output logic signed [4:0] semitones,
  output logic              cfg_err,
  output logic [IW:0]       drop_count,
  pitch_shift_sequencer_if.master bus
);

  localparam logic [IW:0] LAST_IDX = (IW+1)'(SAMPLES - 1);
  localparam logic [IW:0] ONE_IDX  = (IW+1)'(1);

  seq_state_t      state_r;
  seq_state_t      state_s;
  logic [IW:0]     idx_r;
  logic            slot_vld_r;
  logic [IW-1:0]   slot_idx_r;
  logic            hold_vld_r;
  logic [SIZE-1:0] hold_data_r;
  logic [IW:0]     drop_r;

  logic            wr_pend_s;
  logic            stall_s;
  logic            slot_done_s;
  logic            rd_fire_s;
  logic            last_rd_s;
  logic            load_s;
`ifdef PITCH_SEQ_CLEAR_EN
  logic            clr_fire_s;
`endif

  pitch_seq_cfg u_cfg (
    .clk             (clk),
    .rst             (rst),
    .shift_semitones (shift_semitones),
    .shift_wr_en     (shift_wr_en),
    .load            (load_s),
    .semitones       (semitones),
    .cfg_err         (cfg_err)
  );

  // slot handshake: an overflowed slot is dropped and never waits on ready
  always_comb begin
    wr_pend_s   = slot_vld_r & ~bus.shf_ovf;
    stall_s     = wr_pend_s & ~bus.dst_wr_ready;
    slot_done_s = slot_vld_r & ~stall_s;
    rd_fire_s   = (state_r == ST_SHIFT) & ~stall_s;
    last_rd_s   = rd_fire_s & (idx_r == LAST_IDX);
`ifdef PITCH_SEQ_CLEAR_EN
    clr_fire_s  = (state_r == ST_CLEAR) & bus.dst_wr_ready;
`endif
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s = 1'b1;
`ifdef PITCH_SEQ_CLEAR_EN
          state_s = ST_CLEAR;
`else
          state_s = ST_SHIFT;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
`ifdef PITCH_SEQ_CLEAR_EN
        if (clr_fire_s && (idx_r == LAST_IDX)) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_CLEAR;
        end
`else
        state_s = ST_IDLE;
`endif
      end
      ST_SHIFT: begin
        if (last_rd_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DRAIN: begin
        if (slot_done_s) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // state, index counter, in-flight slot, stall hold register, drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= {(IW+1){1'b0}};
      slot_vld_r  <= 1'b0;
      slot_idx_r  <= {IW{1'b0}};
      hold_vld_r  <= 1'b0;
      hold_data_r <= {SIZE{1'b0}};
      drop_r      <= {(IW+1){1'b0}};
    end else begin
      state_r <= state_s;
      if (load_s) begin
        idx_r      <= {(IW+1){1'b0}};
        slot_vld_r <= 1'b0;
        hold_vld_r <= 1'b0;
        drop_r     <= {(IW+1){1'b0}};
      end else begin
`ifdef PITCH_SEQ_CLEAR_EN
        if (clr_fire_s) begin
          idx_r <= (idx_r == LAST_IDX) ? {(IW+1){1'b0}} : idx_r + ONE_IDX;
        end
`endif
        if (rd_fire_s) begin
          slot_vld_r <= 1'b1;
          slot_idx_r <= idx_r[IW-1:0];
          idx_r      <= idx_r + ONE_IDX;
        end else if (slot_done_s) begin
          slot_vld_r <= 1'b0;
        end
        // read data is only valid for one cycle, so keep it across a stall
        if (stall_s && !hold_vld_r) begin
          hold_vld_r  <= 1'b1;
          hold_data_r <= bus.src_rd_data;
        end else if (slot_done_s) begin
          hold_vld_r <= 1'b0;
        end
        if (slot_vld_r && bus.shf_ovf) begin
          drop_r <= drop_r + ONE_IDX;
        end
      end
    end
  end

  // bus outputs, forced to zero when idle
  always_comb begin
    busy             = (state_r != ST_IDLE);
    done             = (state_r == ST_FIN);
    drop_count       = drop_r;
    bus.src_rd_en    = rd_fire_s;
    bus.src_rd_addr  = rd_fire_s ? idx_r[IW-1:0] : {IW{1'b0}};
    bus.shf_in_index = slot_vld_r ? slot_idx_r : {IW{1'b0}};
    if (!slot_vld_r) begin
      bus.shf_data_in = {SIZE{1'b0}};
    end else if (hold_vld_r) begin
      bus.shf_data_in = hold_data_r;
    end else begin
      bus.shf_data_in = bus.src_rd_data;
    end
`ifdef PITCH_SEQ_CLEAR_EN
    if (state_r == ST_CLEAR) begin
      bus.dst_wr_en   = 1'b1;
      bus.dst_wr_addr = idx_r[IW-1:0];
      bus.dst_wr_data = {SIZE{1'b0}};
    end else begin
      bus.dst_wr_en   = wr_pend_s;
      bus.dst_wr_addr = wr_pend_s ? bus.shf_out_index : {IW{1'b0}};
      bus.dst_wr_data = wr_pend_s ? bus.shf_data_out : {SIZE{1'b0}};
    end
`else
    bus.dst_wr_en   = wr_pend_s;
    bus.dst_wr_addr = wr_pend_s ? bus.shf_out_index : {IW{1'b0}};
    bus.dst_wr_data = wr_pend_s ? bus.shf_data_out : {SIZE{1'b0}};
`endif
  end

endmodule

// File: tb/tb_pitch_shift_sequencer.sv
// Randomized bench for pitch_shift_sequencer with a frame-level reference model
// (expected write list, drops, latency). Honors PITCH_SEQ_CLEAR_EN.
module tb_pitch_shift_sequencer;

  localparam int SIZE    = 32;
  localparam int SAMPLES = 2048;
  localparam int IW      = 11;
`ifdef PITCH_SEQ_CLEAR_EN
  localparam int CLR_LAT = SAMPLES;
`else
  localparam int CLR_LAT = 0;
`endif
  localparam int LAT = SAMPLES + 2 + CLR_LAT;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic signed [4:0] shift_semitones;
  logic              shift_wr_en;
  logic signed [4:0] semitones;
  logic              cfg_err;
  logic [IW:0]       drop_count;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  pitch_shift_sequencer_if #(.SIZE(SIZE), .IW(IW)) bus ();

  pitch_shift_sequencer #(.SIZE(SIZE), .SAMPLES(SAMPLES)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .shift_semitones (shift_semitones),
    .shift_wr_en     (shift_wr_en),
    .semitones       (semitones),
    .cfg_err         (cfg_err),
    .drop_count      (drop_count),
    .bus             (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Linear pitch map: coefficient (12+s)/12, so +12 doubles the bin index.
  function automatic int map_idx(input int k, input int s);
    return (k * (12 + s)) / 12;
  endfunction

  // Environment: source memory, shift datapath, destination ready.
  logic [SIZE-1:0] src_mem [SAMPLES];
  int dp_m;
  int rdy_mode;
  int forced_left;

  always @(posedge clk)
    bus.src_rd_data <= bus.src_rd_en ? src_mem[bus.src_rd_addr] : $urandom();

  always_comb begin
    dp_m              = map_idx(int'(bus.shf_in_index), int'(semitones));
    bus.shf_ovf       = (dp_m >= SAMPLES);
    bus.shf_out_index = dp_m[IW-1:0];
    bus.shf_data_out  = bus.shf_data_in + dp_m[SIZE-1:0];
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: bus.dst_wr_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (bus.dst_wr_en && bus.shf_in_index == 11'd5 && forced_left > 0) begin
          bus.dst_wr_ready = 1'b0;
          forced_left--;
        end else begin
          bus.dst_wr_ready = 1'b1;
        end
      end
      default: bus.dst_wr_ready = 1'b1;
    endcase
  end

  // Monitor, sampled mid-cycle.
  logic [IW-1:0]   wa_q [$];
  logic [SIZE-1:0] wd_q [$];
  int first_rd;
  int stab_err;
  int stall_rd_err;
  logic prev_stall;
  logic [IW-1:0]   prev_addr;
  logic [SIZE-1:0] prev_data;

  always @(negedge clk) begin
    if (bus.dst_wr_en && bus.dst_wr_ready) begin
      wa_q.push_back(bus.dst_wr_addr);
      wd_q.push_back(bus.dst_wr_data);
    end
    if (bus.src_rd_en && first_rd < 0) first_rd = int'(bus.src_rd_addr);
    if (prev_stall && (!bus.dst_wr_en || bus.dst_wr_addr != prev_addr ||
                       bus.dst_wr_data != prev_data)) stab_err++;
    if (bus.dst_wr_en && !bus.dst_wr_ready && bus.src_rd_en) stall_rd_err++;
    prev_stall = bus.dst_wr_en && !bus.dst_wr_ready;
    prev_addr  = bus.dst_wr_addr;
    prev_data  = bus.dst_wr_data;
  end

  task automatic cfg_write(input int v);
    @(posedge clk); #1;
    shift_semitones = v[4:0];
    shift_wr_en     = 1'b1;
    @(posedge clk); #1;
    shift_wr_en     = 1'b0;
  endtask

  task automatic prep_frame(input int mode);
    foreach (src_mem[i]) src_mem[i] = $urandom();
    wa_q.delete();
    wd_q.delete();
    first_rd     = -1;
    stab_err     = 0;
    stall_rd_err = 0;
    prev_stall   = 1'b0;
    rdy_mode     = mode;
    forced_left  = 3;
  endtask

  // One frame; extra=1 also pulses start and writes +7 while busy.
  task automatic run_frame(input int s_exp, input int mode, input int exp_lat, input bit extra);
    int t0, lat, got, busy_err, exp_drop, mism;
    logic [IW-1:0]   ea [$];
    logic [SIZE-1:0] ed [$];
    prep_frame(mode);
    got = 0; lat = 0; busy_err = 0;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("semi_active", int'(semitones), s_exp);
    for (int i = 0; i < 20000 && got == 0; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        lat = cyc - t0;
      end else if (!busy) begin
        busy_err++;
      end
      start       = extra && (i == 50);
      shift_wr_en = extra && (i == 60);
      if (extra && i == 60) shift_semitones = 5'sd7;
    end
    check_eq("done_seen", got, 1);
    if (exp_lat > 0) check_eq("latency", lat, exp_lat);
    check_eq("busy_in_frame", busy_err, 0);
    check_eq("semi_held", int'(semitones), s_exp);
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("idle_after_fin", busy, 0);
    // reference: optional zero pass, then bin k lands at map(k) unless past the end
`ifdef PITCH_SEQ_CLEAR_EN
    for (int k = 0; k < SAMPLES; k++) begin
      ea.push_back(k[IW-1:0]);
      ed.push_back(32'd0);
    end
`endif
    exp_drop = 0;
    for (int k = 0; k < SAMPLES; k++) begin
      int m;
      m = map_idx(k, s_exp);
      if (m >= SAMPLES) begin
        exp_drop++;
      end else begin
        ea.push_back(m[IW-1:0]);
        ed.push_back(src_mem[k] + m[SIZE-1:0]);
      end
    end
    mism = 0;
    for (int i = 0; i < ea.size(); i++)
      if (i >= wa_q.size() || wa_q[i] != ea[i] || wd_q[i] != ed[i]) mism++;
    check_eq("wr_count", wa_q.size(), ea.size());
    check_eq("wr_items_bad", mism, 0);
    check_eq("drop_count", drop_count, exp_drop);
    check_eq("first_rd_addr", first_rd, 0);
    check_eq("stall_stable_err", stab_err, 0);
    check_eq("stall_read_err", stall_rd_err, 0);
  endtask

  task automatic reset_mid_frame();
    int got, dn;
    prep_frame(0);
    got = 0; dn = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5000 && got == 0; i++) begin
      @(negedge clk);
      if (bus.src_rd_en && bus.src_rd_addr == 11'd100) got = 1;
    end
    check_eq("reach_k100", got, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd_en", bus.src_rd_en, 0);
    check_eq("rst_wr_en", bus.dst_wr_en, 0);
    check_eq("rst_semi", int'(semitones), 0);
    check_eq("rst_drop", drop_count, 0);
    check_eq("rst_cfg_err", cfg_err, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check_eq("no_done_after_rst", dn, 0);
  endtask

  initial begin
    int r;
    rst = 1'b1; start = 1'b0; shift_wr_en = 1'b0; shift_semitones = 5'sd0;
    rdy_mode = 0; forced_left = 0; first_rd = -1; prev_stall = 1'b0;
    bus.dst_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_rd_en", bus.src_rd_en, 0);
    check_eq("reset_wr_en", bus.dst_wr_en, 0);
    check_eq("reset_semi", int'(semitones), 0);
    check_eq("reset_cfg_err", cfg_err, 0);
    check_eq("reset_drop", drop_count, 0);
    check_eq("reset_rd_addr", bus.src_rd_addr, 0);
    check_eq("reset_wr_addr", bus.dst_wr_addr, 0);
    check_eq("reset_shf_idx", bus.shf_in_index, 0);
    rst = 1'b0;

    run_frame(0, 0, LAT, 1'b0);
    cfg_write(12);
    run_frame(12, 0, LAT, 1'b1);
    run_frame(7, 2, LAT + 3, 1'b0);

    cfg_write(13);
    @(negedge clk);
    check_eq("cfg_err_set", cfg_err, 1);
    check_eq("semi_after_bad", int'(semitones), 7);
    cfg_write(-12);
    @(negedge clk);
    check_eq("cfg_err_sticky", cfg_err, 1);
    run_frame(-12, 1, -1, 1'b0);

    r = int'($urandom_range(0, 24)) - 12;
    cfg_write(r);
    run_frame(r, 1, -1, 1'b0);

    reset_mid_frame();
    run_frame(0, 0, LAT, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
